fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning address/instruction width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning instruction-buffer entries (power of 2, >=2).
REQ-003 The block SHALL have parameter MAX_OUT, default 2, meaning maximum outstanding memory requests (1..DEPTH).
REQ-004 The block SHALL have parameter RESET_PC, default 32'h01000000, meaning first fetch address.
REQ-005 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port mem_req_valid  output  1  fetch request.
REQ-008 The block SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-009 The block SHALL have port mem_req_addr  output  XLEN  fetch address.
REQ-010 The block SHALL have port mem_resp_valid  input  1  response strobe; responses return in request order.
REQ-011 The block SHALL have port mem_resp_data  input  XLEN  fetched instruction word.
REQ-012 The block SHALL have port redirect_valid  input  1  branch/jump redirect.
REQ-013 The block SHALL have port redirect_pc  input  XLEN  redirect target.
REQ-014 The block SHALL have port inst_valid  output  1  head entry valid for decode.
REQ-015 The block SHALL have port inst_ready  input  1  decode consumes head.
REQ-016 The block SHALL have port inst_data  output  XLEN  head instruction.
REQ-017 The block SHALL have port inst_pc  output  XLEN  PC of head instruction.
REQ-018 The block SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-019 Request fires when mem_req_valid && mem_req_ready; fetch_pc then advances by 4 (wraps modulo 2^XLEN).
REQ-020 mem_req_valid SHALL be 1 only when count + outstanding < DEPTH and outstanding < MAX_OUT and state is RUN; mem_req_addr = fetch_pc, held stable while valid && !ready.
REQ-021 Each issued request SHALL carry its PC in an in-order tag FIFO (MAX_OUT deep); on an accepted response, data is written with the popped tag PC.
REQ-022 Space reservation (REQ-020) guarantees no response ever finds the queue full; no backpressure on responses exists.
REQ-023 inst_valid = (count != 0); inst_data/inst_pc show head combinationally from storage; pop when inst_valid && inst_ready.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; a push into an empty queue becomes visible on inst_valid the next cycle (1-cycle response-to-decode latency).
REQ-025 States: RUN, DRAIN. RUN -> DRAIN on redirect_valid when outstanding (after this cycle's issue) > 0; RUN -> RUN on redirect with none outstanding; DRAIN -> RUN when the discard counter reaches 0.
REQ-026 On redirect_valid: queue flushed (count=0), tag FIFO cleared, fetch_pc = redirect_pc, discard counter = outstanding including any request accepted that same cycle; any same-cycle pop or response is dropped.
REQ-027 In DRAIN, each mem_resp_valid decrements the discard counter and its data is discarded; no requests issue.
REQ-028 redirect_valid during DRAIN SHALL reload fetch_pc, keep DRAIN, and keep discard counter = remaining outstanding (minus same-cycle response).
REQ-029 redirect_pc with bits [1:0] nonzero SHALL be used as-is (alignment checked elsewhere).

Reset
REQ-030 While rst_n=0: state=RUN, fetch_pc=RESET_PC, count=0, outstanding=0, discard=0, mem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
REQ-031 Reset asserted mid-operation SHALL drop all buffered and in-flight instructions; responses arriving in the first cycle after release SHALL be ignored only if outstanding=0 (i.e. memory is reset with the block).

Verification
REQ-032 Reset release, mem_req_ready=1, 1-cycle response, inst_ready=1 -> addresses 0x01000000,0x01000004,... issued back-to-back; inst_pc sequence matches, one instruction per cycle.
REQ-033 inst_ready=0 with DEPTH=4 -> exactly 4 requests total issued, count=4, mem_req_valid=0; one pop -> exactly one new request.
REQ-034 mem_req_ready=0 for 3 cycles -> mem_req_addr held at same value, fetch_pc unchanged.
REQ-035 Redirect to 0x01000100 with 2 outstanding -> DRAIN, next 2 responses discarded, count=0, next request addr 0x01000100.
REQ-036 Redirect same cycle as pop and response -> count=0 next cycle, popped and responded words never appear on inst_*.
REQ-037 fetch_pc=0xFFFFFFFC -> next request address 0x00000000.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer between the fetch-address
// generator and decode.
//
// Issues sequential fetch requests, tracks the PC of every in-flight request
// in an in-order tag FIFO, and buffers returned words until decode consumes
// them. A redirect flushes the buffer and enters DRAIN until every request
// still in flight has returned and been thrown away.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   mem_req_valid/ready/addr        fetch request handshake and address
//   mem_resp_valid/data             in-order response strobe and word
//   redirect_valid/pc               branch/jump redirect
//   inst_valid/ready/data/pc        head of the buffer towards decode
//   count                           occupied buffer entries
module fetch_queue #(
   parameter int             XLEN     = 32,
   parameter int             DEPTH    = 4,
   parameter int             MAX_OUT  = 2,
   parameter logic [XLEN-1:0] RESET_PC = 'h0100_0000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic [XLEN-1:0]          mem_req_addr,
   input  logic                     mem_resp_valid,
   input  logic [XLEN-1:0]          mem_resp_data,
   input  logic                     redirect_valid,
   input  logic [XLEN-1:0]          redirect_pc,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic [XLEN-1:0]          inst_data,
   output logic [XLEN-1:0]          inst_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int OW = $clog2(MAX_OUT + 1);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t          state;
   logic [XLEN-1:0] fetch_pc;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   discard;

   logic [XLEN-1:0] q_data [DEPTH];
   logic [XLEN-1:0] q_pc   [DEPTH];
   logic [AW-1:0]   head, tail;

   logic [XLEN-1:0] tag_pc [MAX_OUT];
   logic [TW-1:0]   tag_rd, tag_wr;

   logic            issue_ok, fire, resp_hit, push, pop;
   logic [OW-1:0]   out_next;

   function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
      return (p == TW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   // Reserving buffer space for every outstanding request means a response
   // can always be written, so the response side needs no backpressure.
   assign issue_ok = (state == RUN)
                   && (int'(count) + int'(outstanding) < DEPTH)
                   && (int'(outstanding) < MAX_OUT);
   assign mem_req_valid = rst_n && issue_ok;
   assign mem_req_addr  = fetch_pc;
   assign fire          = mem_req_valid && mem_req_ready;

   // A response with nothing outstanding cannot belong to us (memory was
   // reset along with this block) and is ignored.
   assign resp_hit = mem_resp_valid && (outstanding != '0);
   assign push     = (state == RUN) && resp_hit && !redirect_valid;
   assign pop      = inst_valid && inst_ready && !redirect_valid;

   // In-flight count after this cycle's issue and return.
   assign out_next = outstanding + OW'(fire) - OW'(resp_hit);

   assign inst_valid = (count != '0);
   assign inst_data  = q_data[head];
   assign inst_pc    = q_pc[head];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         count       <= '0;
         head        <= '0;
         tail        <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_data[i] <= '0;
            q_pc[i]   <= '0;
         end
         for (int i = 0; i < MAX_OUT; i++) tag_pc[i] <= '0;
      end else begin
         outstanding <= out_next;
         if (fire) fetch_pc <= fetch_pc + XLEN'(4);
         // A request issued in the redirect cycle is already stale: it is
         // counted for discard but gets no tag.
         if (fire && !redirect_valid) begin
            tag_pc[tag_wr] <= fetch_pc;
            tag_wr         <= tag_inc(tag_wr);
         end
         if (push) begin
            q_data[tail] <= mem_resp_data;
            q_pc[tail]   <= tag_pc[tag_rd];
            tail         <= tail + 1'b1;
            tag_rd       <= tag_inc(tag_rd);
         end
         if (pop) head <= head + 1'b1;
         count <= count + CW'(push) - CW'(pop);

         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
            discard  <= out_next;
            state    <= (out_next != '0) ? DRAIN : RUN;
         end else if (state == DRAIN) begin
            // Every request in flight is stale while draining.
            discard <= discard - OW'(resp_hit);
            if (discard - OW'(resp_hit) == '0) state <= RUN;
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized scoreboard bench for fetch_queue.
// The driver runs just after each rising edge: it folds the previous edge's
// events into a PC-level reference model (epoch-tagged in-flight list and an
// expected-instruction queue), checks the request side, and picks new inputs.
// The monitor runs just after each falling edge and checks count, inst_valid
// and every popped instruction against the expected queue.
module tb_fetch_queue;
   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam int          MAX_OUT  = 2;
   localparam logic [31:0] RESET_PC = 32'h0100_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req_valid, mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, inst_ready;
   logic [31:0] inst_data, inst_pc;
   logic [2:0]  count;

   always #5 clk = ~clk;

   fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
      .count(count)
   );

   typedef struct { logic [31:0] addr; int epoch; } infl_t;
   typedef struct { logic [31:0] pc; logic [31:0] data; } inst_t;

   infl_t       inflight[$];   // requests memory still owes, oldest first
   inst_t       exp_q[$];      // instructions decode should see, in order
   int          epoch;
   logic [31:0] exp_pc;

   int errors = 0, checks = 0;
   int pops = 0, nfire = 0;
   bit run = 0;
   int pr_ready = 0, pr_resp = 0, pr_inst = 0, pr_redir = 0;
   int force_req = 0, force_ack = 0;
   logic [31:0] force_pc = '0;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
   endfunction

   function automatic bit pct(input int p);
      return $urandom_range(99, 0) < p;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Driver + request-side model
   initial begin
      bit p_fire, p_resp, p_redir, prev_hold, drain, exp_v;
      logic [31:0] p_addr, p_rpc, prev_addr;
      infl_t h;
      p_fire = 0; p_resp = 0; p_redir = 0; prev_hold = 0;
      p_addr = '0; p_rpc = '0; prev_addr = '0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
      redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
      forever begin
         @(posedge clk); #1;
         if (!run) begin
            p_fire = 0; p_resp = 0; p_redir = 0; prev_hold = 0;
            continue;
         end
         // previous edge: memory return, then issue, then redirect
         if (p_resp) begin
            h = inflight.pop_front();
            if (!p_redir && h.epoch == epoch) exp_q.push_back('{h.addr, data_of(h.addr)});
         end
         if (p_fire) begin
            inflight.push_back('{p_addr, epoch});
            exp_pc += 32'd4;
         end
         if (p_redir) begin
            epoch++;
            exp_q.delete();
            exp_pc = p_rpc;
         end
         // stale requests in flight mean the block must be draining
         drain = 0;
         foreach (inflight[i]) if (inflight[i].epoch != epoch) drain = 1;
         exp_v = !drain && (exp_q.size() + inflight.size() < DEPTH) && (inflight.size() < MAX_OUT);
         check("req_valid", 32'(mem_req_valid), 32'(exp_v));
         if (prev_hold && mem_req_valid) check("addr_hold", mem_req_addr, prev_addr);
         // new inputs
         mem_req_ready  = pct(pr_ready);
         mem_resp_valid = (inflight.size() != 0) && pct(pr_resp);
         mem_resp_data  = mem_resp_valid ? data_of(inflight[0].addr) : $urandom;
         inst_ready     = pct(pr_inst);
         if (force_req != force_ack) begin
            force_ack = force_req;
            redirect_valid = 1;
            redirect_pc = force_pc;
         end else begin
            redirect_valid = pct(pr_redir);
            redirect_pc = $urandom;
         end
         p_fire = mem_req_valid && mem_req_ready;
         p_addr = mem_req_addr;
         if (p_fire) begin
            nfire++;
            check("req_addr", mem_req_addr, exp_pc);
         end
         p_resp = mem_resp_valid;
         p_redir = redirect_valid;
         p_rpc = redirect_pc;
         prev_hold = mem_req_valid && !mem_req_ready && !redirect_valid;
         prev_addr = mem_req_addr;
      end
   end

   // Monitor: decode side
   initial begin
      inst_t e;
      forever begin
         @(negedge clk); #1;
         if (run) begin
            check("count", 32'(count), 32'(exp_q.size()));
            check("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
            if (inst_valid && inst_ready && !redirect_valid && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("inst_pc", inst_pc, e.pc);
               check("inst_data", inst_data, e.data);
               pops++;
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic set_p(input int r, input int s, input int i, input int d);
      pr_ready = r; pr_resp = s; pr_inst = i; pr_redir = d;
   endtask

   initial begin
      int f0;
      epoch = 0;
      exp_pc = RESET_PC;
      cycles(3);
      check("rst_req_valid", 32'(mem_req_valid), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_inst_data", inst_data, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_req_addr", mem_req_addr, RESET_PC);
      rst_n = 1;
      run = 1;

      // streaming: one instruction per cycle after the pipeline fills
      set_p(100, 100, 100, 0);
      pops = 0;
      cycles(30);
      check("throughput", 32'(pops >= 26), 32'd1);

      // decode stalled: buffer fills and requests stop
      set_p(100, 100, 0, 0);
      cycles(15);
      check("full_count", 32'(count), 32'd4);
      check("full_req_valid", 32'(mem_req_valid), 32'd0);
      f0 = nfire;
      pr_inst = 100;
      cycles(1);
      pr_inst = 0;
      cycles(6);
      check("one_pop_one_req", 32'(nfire - f0), 32'd1);

      // memory stalls requests: address held (checked by driver)
      set_p(0, 100, 100, 0);
      cycles(4);
      check("stall_addr", mem_req_addr, exp_pc);

      // redirect with two requests in flight
      set_p(100, 0, 100, 0);
      cycles(4);
      force_pc = 32'h0100_0100;
      force_req++;
      cycles(2);
      check("drain_count", 32'(count), 32'd0);
      check("drain_no_req", 32'(mem_req_valid), 32'd0);
      pr_resp = 100;
      cycles(10);

      // address wrap at the top of the space
      set_p(100, 100, 100, 0);
      force_pc = 32'hFFFF_FFF8;
      force_req++;
      cycles(12);

      // redirect colliding with pop and response
      set_p(100, 100, 100, 0);
      cycles(3);
      force_pc = 32'h0200_0002;
      force_req++;
      cycles(2);
      check("redir_flush", 32'(count), 32'd0);
      cycles(5);

      // random mix
      for (int k = 0; k < 25; k++) begin
         set_p($urandom_range(100, 20), $urandom_range(100, 20),
               $urandom_range(100, 10), $urandom_range(15, 0));
         cycles(100);
      end

      run = 0;
      cycles(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
